// File: rtl/instr_seq_if.sv
// Load, control and issue signals between the program source and instr_sequencer.
// AW sets the width of prog_len (AW+1 bits, so a full buffer of 2**AW words can be counted).
interface instr_seq_if #(
  parameter int AW = 4
);
  logic          ld_valid;
  logic          ld_ready;
  logic [7:0]    ld_opcode;
  logic [3:0]    ld_a;
  logic [3:0]    ld_b;
  logic          start;
  logic          hold;
  logic          clear;
  logic [15:0]   instruction;
  logic          issue_valid;
  logic          busy;
  logic [AW:0]   prog_len;
  logic          err;

  modport master (
    output ld_valid, ld_opcode, ld_a, ld_b, start, hold, clear,
    input  ld_ready, instruction, issue_valid, busy, prog_len, err
  );

  modport slave (
    input  ld_valid, ld_opcode, ld_a, ld_b, start, hold, clear,
    output ld_ready, instruction, issue_valid, busy, prog_len, err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Loads scrubbed instruction words into a program buffer and issues them one per cycle.
// Optional ISSUE_LOOP_EN: wrap back to mem[0] at end of program instead of halting in DONE.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | loading allowed; waiting for start
// ST_RUN  | issuing program words (hold stalls one cycle)
// ST_DONE | program finished; buffer retained, start re-runs
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  instr_seq_if.slave  bus
);

  localparam logic [15:0] LP_NOP    = 16'h1700;
  localparam logic [7:0]  LP_MAX_OP = 8'd23;
  localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE    = (AW+1)'(1);
  localparam logic [AW:0] LP_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_count;
  logic [AW:0] w_count_nxt;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_rd_ptr_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic        r_issue_valid;
  logic        w_issue_valid_nxt;
  logic        r_busy;
  logic        r_err;
  logic        w_err_nxt;
  logic        w_ld_ready;
  logic        w_accept;
  logic        w_ld_illegal;
  logic [15:0] w_ld_word;
  logic [15:0] w_mem_head;
  logic [15:0] w_mem_rd;

  assign w_ld_ready   = (r_state == ST_IDLE) && (r_count < LP_DEPTH);
  assign w_accept     = bus.ld_valid & w_ld_ready & ~bus.clear;
  assign w_ld_illegal = bus.ld_opcode > LP_MAX_OP;
  assign w_ld_word    = w_ld_illegal ? LP_NOP : {bus.ld_opcode, bus.ld_a, bus.ld_b};

  // A word loaded into an empty buffer on the start edge is forwarded straight to issue.
  assign w_mem_head = (w_accept && (r_count == LP_ZERO)) ? w_ld_word : r_mem[0];
  assign w_mem_rd   = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = w_accept ? (r_count + LP_ONE) : r_count;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_instr_nxt       = LP_NOP;
    w_issue_valid_nxt = 1'b0;
    w_err_nxt         = r_err | (w_accept & w_ld_illegal);

    if (bus.clear) begin
      w_state_nxt  = ST_IDLE;
      w_count_nxt  = LP_ZERO;
      w_rd_ptr_nxt = LP_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && ((r_count != LP_ZERO) || w_accept)) begin
            w_state_nxt       = ST_RUN;
            w_instr_nxt       = w_mem_head;
            w_issue_valid_nxt = 1'b1;
            w_rd_ptr_nxt      = LP_ONE;
          end
        end
        ST_RUN: begin
          if (bus.hold) begin
            w_rd_ptr_nxt = r_rd_ptr;
          end else if (r_rd_ptr < r_count) begin
            w_instr_nxt       = w_mem_rd;
            w_issue_valid_nxt = 1'b1;
            w_rd_ptr_nxt      = r_rd_ptr + LP_ONE;
          end else begin
`ifdef ISSUE_LOOP_EN
            w_instr_nxt       = r_mem[0];
            w_issue_valid_nxt = 1'b1;
            w_rd_ptr_nxt      = LP_ONE;
`else
            w_state_nxt       = ST_DONE;
`endif
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            w_state_nxt       = ST_RUN;
            w_instr_nxt       = r_mem[0];
            w_issue_valid_nxt = 1'b1;
            w_rd_ptr_nxt      = LP_ONE;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_count_nxt  = LP_ZERO;
          w_rd_ptr_nxt = LP_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_count       <= LP_ZERO;
      r_rd_ptr      <= LP_ZERO;
      r_instr       <= LP_NOP;
      r_issue_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_instr       <= w_instr_nxt;
      r_issue_valid <= w_issue_valid_nxt;
      r_busy        <= (w_state_nxt == ST_RUN);
      r_err         <= w_err_nxt;
    end
  end

  // Buffer storage has no reset; entries at or beyond count are never read.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_accept) begin
      r_mem[r_count[AW-1:0]] <= w_ld_word;
    end
  end

  assign bus.ld_ready    = w_ld_ready;
  assign bus.instruction = r_instr;
  assign bus.issue_valid = r_issue_valid;
  assign bus.busy        = r_busy;
  assign bus.prog_len    = r_count;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: queue-based program model compared every cycle,
// plus directed scenarios with literal expected words.
module tb_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [15:0] NOP = 16'h1700;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  instr_seq_if #(.AW(AW)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program as a queue, issue position as a plain index.
  logic [15:0] prog [$];
  bit          m_run, m_done, m_init;
  int          m_pos;
  logic [15:0] m_instr;
  bit          m_iv, m_err;

  always @(posedge clk) begin
    m_init = 1'b1;
    if (!rst_n) begin
      prog.delete();
      m_run = 0; m_done = 0; m_pos = 0; m_instr = NOP; m_iv = 0; m_err = 0;
    end else if (bus.clear) begin
      prog.delete();
      m_run = 0; m_done = 0; m_pos = 0; m_instr = NOP; m_iv = 0;
    end else begin
      if (!m_run && !m_done && bus.ld_valid && prog.size() < DEPTH) begin
        if (bus.ld_opcode > 8'd23) begin
          prog.push_back(NOP);
          m_err = 1;
        end else begin
          prog.push_back({bus.ld_opcode, bus.ld_a, bus.ld_b});
        end
      end
      if (!m_run && bus.start && prog.size() > 0) begin
        m_run = 1; m_done = 0; m_instr = prog[0]; m_iv = 1; m_pos = 1;
      end else if (m_run) begin
        if (bus.hold) begin
          m_instr = NOP; m_iv = 0;
        end else if (m_pos < prog.size()) begin
          m_instr = prog[m_pos]; m_iv = 1; m_pos++;
        end else begin
`ifdef ISSUE_LOOP_EN
          m_instr = prog[0]; m_iv = 1; m_pos = 1;
`else
          m_instr = NOP; m_iv = 0; m_run = 0; m_done = 1;
`endif
        end
      end else begin
        m_instr = NOP; m_iv = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (m_init) begin
      chk("model_instruction", 32'(bus.instruction), 32'(m_instr));
      chk("model_issue_valid", 32'(bus.issue_valid), 32'(m_iv));
      chk("model_busy",        32'(bus.busy),        32'(m_run));
      chk("model_err",         32'(bus.err),         32'(m_err));
      chk("model_prog_len",    32'(bus.prog_len),    32'(prog.size()));
      chk("model_ld_ready",    32'(bus.ld_ready),
          32'(!m_run && !m_done && prog.size() < DEPTH));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.ld_valid = 1'b1; bus.ld_opcode = op; bus.ld_a = a; bus.ld_b = b;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ld_valid = 0; bus.ld_opcode = 0; bus.ld_a = 0; bus.ld_b = 0;
    bus.start = 0; bus.hold = 0; bus.clear = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_instruction", 32'(bus.instruction), 32'h1700);
    chk("rst_issue_valid", 32'(bus.issue_valid), 0);
    chk("rst_busy",        32'(bus.busy), 0);
    chk("rst_err",         32'(bus.err), 0);
    chk("rst_prog_len",    32'(bus.prog_len), 0);
    chk("rst_ld_ready",    32'(bus.ld_ready), 1);

    // two-word program
    load(8'h01, 4'h2, 4'h5);
    load(8'h00, 4'h3, 4'h2);
    chk("t1_prog_len", 32'(bus.prog_len), 2);
    pulse_start();
    chk("t1_w0", 32'(bus.instruction), 32'h0125);
    chk("t1_v0", 32'(bus.issue_valid), 1);
    tick();
    chk("t1_w1", 32'(bus.instruction), 32'h0032);
    chk("t1_v1", 32'(bus.issue_valid), 1);
    tick();
`ifndef ISSUE_LOOP_EN
    chk("t1_end_instr", 32'(bus.instruction), 32'h1700);
    chk("t1_end_valid", 32'(bus.issue_valid), 0);
    chk("t1_end_busy",  32'(bus.busy), 0);
    chk("t1_done_ld_ready", 32'(bus.ld_ready), 0);
`endif
    pulse_clear();

    // illegal opcode scrubbed, sticky err
    load(8'h30, 4'h1, 4'h1);
    chk("t2_err", 32'(bus.err), 1);
    pulse_start();
    chk("t2_scrubbed", 32'(bus.instruction), 32'h1700);
    chk("t2_scrub_valid", 32'(bus.issue_valid), 1);
    tick();
    pulse_clear();
    chk("t2_err_after_clear", 32'(bus.err), 1);
    chk("t2_len_after_clear", 32'(bus.prog_len), 0);
    do_reset();
    chk("t2_err_after_reset", 32'(bus.err), 0);

    // fill buffer
    for (int i = 0; i < DEPTH; i++) load(8'(i % 24), 4'(i), 4'(15 - i));
    chk("t3_ld_ready_full", 32'(bus.ld_ready), 0);
    chk("t3_len_full",      32'(bus.prog_len), DEPTH);
    load(8'h02, 4'h7, 4'h7);
    chk("t3_len_overflow",  32'(bus.prog_len), DEPTH);
    pulse_start();
    for (int i = 0; i < DEPTH + 1; i++) tick();
    pulse_clear();

    // hold for one cycle after the first issue
    load(8'h0A, 4'h1, 4'h2);
    load(8'h0B, 4'h3, 4'h4);
    load(8'h17, 4'h5, 4'h6);
    pulse_start();
    chk("t4_w0", 32'(bus.instruction), 32'h0A12);
    bus.hold = 1'b1;
    tick();
    bus.hold = 1'b0;
    chk("t4_hold_instr", 32'(bus.instruction), 32'h1700);
    chk("t4_hold_valid", 32'(bus.issue_valid), 0);
    chk("t4_hold_busy",  32'(bus.busy), 1);
    tick();
    chk("t4_w1", 32'(bus.instruction), 32'h0B34);
    tick();
    chk("t4_w2", 32'(bus.instruction), 32'h1756);
    tick();
`ifndef ISSUE_LOOP_EN
    chk("t4_done_busy", 32'(bus.busy), 0);
    pulse_start();
    chk("t4_rerun_w0", 32'(bus.instruction), 32'h0A12);
    for (int i = 0; i < 3; i++) tick();
`endif
    pulse_clear();

    // start with empty buffer is ignored
    pulse_start();
    chk("t5_empty_busy",  32'(bus.busy), 0);
    chk("t5_empty_valid", 32'(bus.issue_valid), 0);
    chk("t5_empty_ready", 32'(bus.ld_ready), 1);

    // load and start on the same edge with an empty buffer
    bus.ld_valid = 1'b1; bus.ld_opcode = 8'h05; bus.ld_a = 4'h1; bus.ld_b = 4'h2;
    bus.start = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.start = 1'b0;
    chk("t6_fwd_word",  32'(bus.instruction), 32'h0512);
    chk("t6_fwd_valid", 32'(bus.issue_valid), 1);
    chk("t6_fwd_len",   32'(bus.prog_len), 1);
    tick();
    pulse_clear();

    // reset in the middle of a run
    load(8'h03, 4'h4, 4'h4);
    load(8'h04, 4'h5, 4'h5);
    load(8'h06, 4'h6, 4'h6);
    pulse_start();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_rst_instr", 32'(bus.instruction), 32'h1700);
    chk("t7_rst_busy",  32'(bus.busy), 0);
    chk("t7_rst_valid", 32'(bus.issue_valid), 0);
    chk("t7_rst_len",   32'(bus.prog_len), 0);

`ifdef ISSUE_LOOP_EN
    load(8'h01, 4'h1, 4'h1);
    load(8'h02, 4'h2, 4'h2);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk("t8_loop_word", 32'(bus.instruction), (i % 2 == 0) ? 32'h0111 : 32'h0222);
      chk("t8_loop_busy", 32'(bus.busy), 1);
      tick();
    end
    pulse_clear();
    chk("t8_loop_cleared", 32'(bus.busy), 0);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
